// File: rtl/rv_defs.sv
// Shared definitions for the uRV multiply/divide unit: M-extension function
// codes, controller state encodings and small decode helpers.
package rv_defs;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_fun_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } md_state_e;

  function automatic logic fun_is_div(md_fun_e f);
    return f[2];
  endfunction

  function automatic logic fun_div_signed(md_fun_e f);
    return !f[0];
  endfunction

endpackage

// File: rtl/rv_divider.sv
// Restoring radix-2 divider core: operand magnitudes, iteration counter and
// the sign/special-case fix-up applied to the final quotient or remainder.
module rv_divider #(
  parameter int g_width = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               signed_i,
  input  logic               rem_i,
  input  logic [g_width-1:0] a_i,
  input  logic [g_width-1:0] b_i,
  output logic               last_o,
  output logic               special_o,
  output logic [g_width-1:0] result_o
);

  localparam int CntW = $clog2(g_width + 1);
  localparam logic [g_width-1:0] MinVal = {1'b1, {(g_width-1){1'b0}}};
  localparam logic [g_width-1:0] Ones   = '1;

  logic               sign_a, sign_b;
  logic [g_width-1:0] a_q, quo_q, dvs_q, rem_q;
  logic [CntW-1:0]    cnt_q;
  logic               neg_quo_q, neg_rem_q, rem_sel_q, bzero_q, ovf_q;
  logic [g_width:0]   shifted, diff;
  logic [g_width-1:0] quo_d, rem_d, quo_res, rem_res;

  assign sign_a = signed_i & a_i[g_width-1];
  assign sign_b = signed_i & b_i[g_width-1];

  // The partial remainder needs one extra bit so the trial subtraction's
  // borrow shows up as the sign of diff.
  assign shifted = {rem_q, quo_q[g_width-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign rem_d   = diff[g_width] ? shifted[g_width-1:0] : diff[g_width-1:0];
  assign quo_d   = {quo_q[g_width-2:0], ~diff[g_width]};

  assign last_o    = (cnt_q == CntW'(1));
  assign special_o = bzero_q | ovf_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values present before the clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q       <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
      bzero_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (load_i) begin
      a_q       <= a_i;
      quo_q     <= sign_a ? -a_i : a_i;
      dvs_q     <= sign_b ? -b_i : b_i;
      rem_q     <= '0;
      cnt_q     <= CntW'(g_width);
      neg_quo_q <= sign_a ^ sign_b;
      neg_rem_q <= sign_a;
      rem_sel_q <= rem_i;
      bzero_q   <= (b_i == '0);
      ovf_q     <= signed_i && (a_i == MinVal) && (b_i == Ones);
    end else if (step_i && (cnt_q != '0)) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    quo_res = neg_quo_q ? -quo_q : quo_q;
    rem_res = neg_rem_q ? -rem_q : rem_q;
    if (bzero_q) begin
      quo_res = Ones;
      rem_res = a_q;
    end else if (ovf_q) begin
      quo_res = a_q;
      rem_res = '0;
    end
    result_o = rem_sel_q ? rem_res : quo_res;
  end

endmodule

// File: rtl/rv_muldiv.sv
// Multi-cycle M-extension unit for the uRV execute stage: pipelined multiplier,
// iterative divider and the controller that stalls the pipeline until done.
module rv_muldiv
  import rv_defs::*;
#(
  parameter int g_width         = 32,
  parameter int g_mul_stages    = 2,
  parameter int g_div_early_out = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               x_stall_i,
  input  logic               x_kill_i,
  input  logic               d_valid_i,
  input  logic               d_is_muldiv_i,
  input  logic [2:0]         d_fun_i,
  input  logic [g_width-1:0] d_rs1_i,
  input  logic [g_width-1:0] d_rs2_i,
  output logic               x_stall_req_o,
  output logic [g_width-1:0] x_rd_o,
  output logic               x_done_o
);

  localparam logic [1:0] MulLast  = 2'(g_mul_stages - 1);
  localparam logic       EarlyOut = (g_div_early_out != 0);

  md_state_e            state_q, state_d;
  md_fun_e              fun_q;
  logic [g_width-1:0]   a_q, b_q, rd_q, rd_d;
  logic [1:0]           mul_cnt_q, mul_cnt_d;
  logic                 start;
  logic                 div_last, div_special;
  logic [g_width-1:0]   div_res, mul_res;
  logic                 a_sgn, b_sgn;
  logic [2*g_width-1:0] a_ext, b_ext, prod_c, prod_r;

  assign start = rst_n_i & d_valid_i & d_is_muldiv_i & ~x_kill_i & (state_q == ST_IDLE);

  // Sign-extending both operands to 2*g_width makes a single modulo-2^(2w)
  // multiply correct for all four signedness combinations.
  assign a_sgn  = ((fun_q == MD_MULH) || (fun_q == MD_MULHSU)) & a_q[g_width-1];
  assign b_sgn  = (fun_q == MD_MULH) & b_q[g_width-1];
  assign a_ext  = {{g_width{a_sgn}}, a_q};
  assign b_ext  = {{g_width{b_sgn}}, b_q};
  assign prod_c = a_ext * b_ext;

  generate
    if (g_mul_stages > 1) begin : g_pipe
      logic [2*g_width-1:0] pipe_q [g_mul_stages-1];
      // NOTE: the retiming stages are few and feed a datapath whose reset
      // value is architecturally visible, so each entry is cleared explicitly.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          for (int i = 0; i < g_mul_stages - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= prod_c;
          for (int i = 1; i < g_mul_stages - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign prod_r = pipe_q[g_mul_stages-2];
    end else begin : g_comb
      assign prod_r = prod_c;
    end
  endgenerate

  assign mul_res = (fun_q == MD_MUL) ? prod_r[g_width-1:0] : prod_r[2*g_width-1:g_width];

  rv_divider #(.g_width(g_width)) u_divider (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .load_i    (start),
    .step_i    (state_q == ST_DIV),
    .signed_i  (fun_div_signed(md_fun_e'(d_fun_i))),
    .rem_i     (d_fun_i[1]),
    .a_i       (d_rs1_i),
    .b_i       (d_rs2_i),
    .last_o    (div_last),
    .special_o (div_special),
    .result_o  (div_res)
  );

  always_comb begin
    state_d       = state_q;
    rd_d          = rd_q;
    mul_cnt_d     = mul_cnt_q;
    x_stall_req_o = 1'b0;
    x_done_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_stall_req_o = 1'b1;
          mul_cnt_d     = '0;
          state_d       = fun_is_div(md_fun_e'(d_fun_i)) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        x_stall_req_o = 1'b1;
        mul_cnt_d     = mul_cnt_q + 2'd1;
        if (mul_cnt_q == MulLast) begin
          state_d = ST_DONE;
          rd_d    = mul_res;
        end
      end
      ST_DIV: begin
        x_stall_req_o = 1'b1;
        if (EarlyOut && div_special) begin
          state_d = ST_DONE;
          rd_d    = div_res;
        end else if (div_last) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        x_stall_req_o = 1'b1;
        state_d       = ST_DONE;
        rd_d          = div_res;
      end
      ST_DONE: begin
        x_done_o = 1'b1;
        if (!x_stall_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A kill abandons whatever is in flight, including a finished result.
    if (x_kill_i) begin
      state_d       = ST_IDLE;
      rd_d          = rd_q;
      x_stall_req_o = 1'b0;
      x_done_o      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      fun_q     <= MD_MUL;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      mul_cnt_q <= mul_cnt_d;
      if (start) begin
        fun_q <= md_fun_e'(d_fun_i);
        a_q   <= d_rs1_i;
        b_q   <= d_rs2_i;
      end
    end
  end

  assign x_rd_o = rd_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// Scoreboard bench for rv_muldiv: the driver queues expected results from a
// plain-arithmetic reference model, a monitor compares them as results retire.
module tb_rv_muldiv;

  localparam int W  = 32;
  localparam int S  = 2;
  localparam int EO = 1;
  localparam logic [31:0] MIN  = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        x_stall = 1'b0, x_kill = 1'b0;
  logic        d_valid = 1'b0, d_is_muldiv = 1'b0;
  logic [2:0]  d_fun = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        stall_req, done;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rv_muldiv #(.g_width(W), .g_mul_stages(S), .g_div_early_out(EO)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .x_stall_i     (x_stall),
    .x_kill_i      (x_kill),
    .d_valid_i     (d_valid),
    .d_is_muldiv_i (d_is_muldiv),
    .d_fun_i       (d_fun),
    .d_rs1_i       (rs1),
    .d_rs2_i       (rs2),
    .x_stall_req_o (stall_req),
    .x_rd_o        (rd),
    .x_done_o      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (fun)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return ONES;
        if (a == MIN && b == ONES) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? ONES : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == ONES) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b);
    if (!fun[2]) return S + 1;
    if (EO != 0 && (b == 0 || (!fun[0] && a == MIN && b == ONES))) return 2;
    return W + 2;
  endfunction

  // Called just after a rising edge; leaves the unit idle one cycle after DONE.
  task automatic run_op(input string name, input logic [2:0] fun, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold);
    int          lat;
    logic        busy_ok;
    logic [31:0] held;
    d_valid = 1'b1; d_is_muldiv = 1'b1; d_fun = fun; rs1 = a; rs2 = b;
    x_stall = (hold > 0);
    exp_q.push_back(exp);
    #1 check({name, " stall_req@start"}, 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    d_valid = 1'b0; d_is_muldiv = 1'b0; d_fun = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    lat = 1; busy_ok = 1'b1;
    while (!done && lat < 200) begin
      if (!stall_req) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat(fun, a, b)));
    check({name, " stall_req busy"}, 32'(busy_ok), 32'd1);
    check({name, " stall_req@done"}, 32'(stall_req), 32'd0);
    if (hold > 0) begin
      held = rd;
      repeat (hold) begin
        @(posedge clk); #1;
        check({name, " held done"}, 32'(done), 32'd1);
        check({name, " held rd"}, rd, held);
      end
      x_stall = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: retire a result whenever DONE is presented and not held.
  always @(negedge clk) begin
    if (rst_n && done && !x_stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=0x%08h expected=no result", rd);
      end else begin
        check("result", rd, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [2:0]  fun;
    logic [31:0] a, b;
    logic        idle_ok;
    int          mode, hold;

    d_valid = 1'b1; d_is_muldiv = 1'b1;
    #12;
    check("reset stall_req", 32'(stall_req), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rd", rd, 32'd0);
    d_valid = 1'b0; d_is_muldiv = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("MUL 7*-3",      3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("MULHU max*max", 3'd3, ONES, ONES, 32'hFFFF_FFFE, 0);
    run_op("DIV -20/3",     3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 0);
    run_op("REM -20/3",     3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 0);
    run_op("DIVU 100/0",    3'd5, 32'd100, 32'd0, ONES, 0);
    run_op("REMU 100/0",    3'd7, 32'd100, 32'd0, 32'd100, 0);
    run_op("DIV min/-1",    3'd4, MIN, ONES, MIN, 0);
    run_op("REM min/-1",    3'd6, MIN, ONES, 32'd0, 0);
    run_op("MULH hold",     3'd1, 32'h1234_5678, 32'hFEDC_BA98, ref_model(3'd1, 32'h1234_5678, 32'hFEDC_BA98), 3);

    // Kill a DIVU in flight at cycle 10: nothing may retire afterwards.
    d_valid = 1'b1; d_is_muldiv = 1'b1; d_fun = 3'd5; rs1 = 32'd1000; rs2 = 32'd7;
    @(posedge clk); #1;
    d_valid = 1'b0; d_is_muldiv = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    x_kill = 1'b1;
    #1;
    check("kill stall_req", 32'(stall_req), 32'd0);
    check("kill done", 32'(done), 32'd0);
    @(posedge clk); #1;
    x_kill = 1'b0;
    idle_ok = 1'b1;
    repeat (40) begin
      if (stall_req || done) idle_ok = 1'b0;
      @(posedge clk); #1;
    end
    check("idle after kill", 32'(idle_ok), 32'd1);
    run_op("MUL 5*5 after kill", 3'd0, 32'd5, 32'd5, 32'd25, 0);

    // Asynchronous reset in the middle of a divide.
    d_valid = 1'b1; d_is_muldiv = 1'b1; d_fun = 3'd4; rs1 = 32'hFFFF_FFEC; rs2 = 32'd3;
    @(posedge clk); #1;
    d_valid = 1'b0; d_is_muldiv = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0; d_valid = 1'b1; d_is_muldiv = 1'b1;
    #1;
    check("async reset stall_req", 32'(stall_req), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    check("async reset rd", rd, 32'd0);
    d_valid = 1'b0; d_is_muldiv = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      fun  = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0: b = 32'd0;
        1: begin a = MIN; b = ONES; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 255);
        default: ;
      endcase
      hold = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
      run_op($sformatf("rand%0d fun%0d", i, fun), fun, a, b, ref_model(fun, a, b), hold);
    end

    repeat (3) @(posedge clk);
    #1 check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
